rom_fetch_unit: RTL and testbench

Bus-master fetch controller for the model computer: owns the program counter and drives the chip-enable and 4-bit address bus of the program ROM. It reads the 8-bit data bus and presents each fetched word to the instruction decoder as opcode/operand with a valid/ready handshake. It sits between the ROM (`CE` active-low, `ABUS[3:0]`, `DBUS[7:0]`) and the controller/decoder.

---
 rtl/rom_fetch_unit_if.sv | 30 +++
 rtl/rom_fetch_unit.sv | 114 +++++++++++
 tb/tb_rom_fetch_unit.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rom_fetch_unit_if.sv
// Fetch-unit bus: ROM side (CE/ABUS/DBUS), decoder handshake and sequencing controls.
// The master modport is the fetch unit; the slave modport is the ROM/decoder/controller side.
interface rom_fetch_unit_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic                start;
    logic                halt;
    logic                jmp;
    logic [ADDR_W-1:0]   jmp_addr;
    logic                CE;
    logic [ADDR_W-1:0]   ABUS;
    logic [DATA_W-1:0]   DBUS;
    logic                instr_valid;
    logic                instr_ready;
    logic [DATA_W/2-1:0] opcode;
    logic [DATA_W/2-1:0] operand;
    logic [ADDR_W-1:0]   pc;
    logic                busy;

    modport master (
        input  start, halt, jmp, jmp_addr, DBUS, instr_ready,
        output CE, ABUS, instr_valid, opcode, operand, pc, busy
    );

    modport slave (
        output start, halt, jmp, jmp_addr, DBUS, instr_ready,
        input  CE, ABUS, instr_valid, opcode, operand, pc, busy
    );
endinterface

// File: rtl/rom_fetch_unit.sv
// Program-ROM fetch controller: owns the PC, runs the CE/ABUS read cycle and
// hands each fetched word to the decoder as opcode/operand over valid/ready.
//
// state  | meaning
// IDLE   | CE high, PC loadable by jmp, waiting for start
// ACCESS | CE low, ABUS=PC, wait counter running until DBUS is sampled
// HOLD   | CE high, instruction presented until the decoder accepts it
module rom_fetch_unit #(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 8,
    parameter int WAIT_CYC = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    rom_fetch_unit_if.master  bus
);
    localparam int         HALF    = DATA_W / 2;
    localparam logic [3:0] LP_WAIT = 4'(WAIT_CYC);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [3:0]        r_cnt;
    logic [HALF-1:0]   r_opcode;
    logic [HALF-1:0]   r_operand;

    state_t            w_state_nxt;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic [3:0]        w_cnt_nxt;
    logic [HALF-1:0]   w_opcode_nxt;
    logic [HALF-1:0]   w_operand_nxt;
    logic              w_ce;
    logic              w_valid;
    logic              w_busy;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_pc      <= '0;
            r_cnt     <= '0;
            r_opcode  <= '0;
            r_operand <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_cnt     <= w_cnt_nxt;
            r_opcode  <= w_opcode_nxt;
            r_operand <= w_operand_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_cnt_nxt     = r_cnt;
        w_opcode_nxt  = r_opcode;
        w_operand_nxt = r_operand;
        w_ce          = 1'b1;
        w_valid       = 1'b0;
        w_busy        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // A jump issued together with start still lands before the first read.
                if (bus.jmp) begin
                    w_pc_nxt = bus.jmp_addr;
                end
                if (bus.start && !bus.halt) begin
                    w_state_nxt = ST_ACCESS;
                    w_cnt_nxt   = '0;
                end
            end

            ST_ACCESS: begin
                w_ce   = 1'b0;
                w_busy = 1'b1;
                if (r_cnt == LP_WAIT) begin
                    w_opcode_nxt  = bus.DBUS[DATA_W-1:HALF];
                    w_operand_nxt = bus.DBUS[HALF-1:0];
                    w_state_nxt   = ST_HOLD;
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end

            ST_HOLD: begin
                w_valid = 1'b1;
                w_busy  = 1'b1;
                if (bus.instr_ready) begin
                    w_pc_nxt    = bus.jmp ? bus.jmp_addr : r_pc + ADDR_W'(1);
                    w_cnt_nxt   = '0;
                    w_state_nxt = bus.halt ? ST_IDLE : ST_ACCESS;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.CE          = w_ce;
    assign bus.ABUS        = r_pc;
    assign bus.pc          = r_pc;
    assign bus.instr_valid = w_valid;
    assign bus.busy        = w_busy;
    assign bus.opcode      = r_opcode;
    assign bus.operand     = r_operand;
endmodule

// File: tb/tb_rom_fetch_unit.sv
// Scoreboard bench for rom_fetch_unit: stimulus queues expected instructions,
// a negedge monitor checks every decoder handshake against them.
module tb_rom_fetch_unit;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   cyc;
    int   hs_cnt;
    int   hs_cyc[$];

    typedef struct {
        logic [3:0] opc;
        logic [3:0] opr;
        logic [3:0] pc;
    } exp_t;
    exp_t exp_q[$];

    logic [7:0] rom [16];

    rom_fetch_unit_if #(.ADDR_W(4), .DATA_W(8)) bus ();

    rom_fetch_unit #(.ADDR_W(4), .DATA_W(8), .WAIT_CYC(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Bus reads back a junk pattern whenever the ROM is not enabled.
    assign bus.DBUS = bus.CE ? 8'hA5 : rom[bus.ABUS];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] a);
        exp_t e;
        e.opc = rom[a][7:4];
        e.opr = rom[a][3:0];
        e.pc  = a;
        exp_q.push_back(e);
    endtask

    task automatic wait_hs(input int n);
        int budget;
        budget = 50;
        while (hs_cnt < n && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        #1;
        if (hs_cnt < n) begin
            total++;
            bad++;
            $display("FAIL wait_hs: got %0d handshakes expected %0d", hs_cnt, n);
        end
    endtask

    // Monitor: ABUS tracks PC every cycle, and each handshake pops one expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("abus_eq_pc", {28'd0, bus.ABUS}, {28'd0, bus.pc});
            if (bus.instr_valid && bus.instr_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_instr: got pc=%0h expected none", bus.pc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("instr", {20'd0, bus.opcode, bus.operand, bus.pc}, {20'd0, e.opc, e.opr, e.pc});
                end
                hs_cnt++;
                hs_cyc.push_back(cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        int n;
        total = 0;
        bad = 0;
        cyc = 0;
        hs_cnt = 0;
        for (int i = 0; i < 16; i++) rom[i] = 8'h10 + 8'(i);
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.halt = 1'b0;
        bus.jmp = 1'b0;
        bus.jmp_addr = 4'h0;
        bus.instr_ready = 1'b0;

        // reset / idle
        repeat (2) tick();
        rst_n = 1'b1;
        chk("rst_busy", {31'd0, bus.busy}, 0);
        chk("rst_opc", {24'd0, bus.opcode, bus.operand}, 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_ce", {31'd0, bus.CE}, 1);
            chk("idle_abus", {28'd0, bus.ABUS}, 0);
            chk("idle_valid", {31'd0, bus.instr_valid}, 0);
        end

        // sequential fetch 0..3
        b = hs_cnt;
        for (int a = 0; a < 4; a++) push(4'(a));
        bus.instr_ready = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("seq_ce0_a", {31'd0, bus.CE}, 0);
        chk("seq_abus0", {28'd0, bus.ABUS}, 0);
        tick();
        chk("seq_ce0_b", {31'd0, bus.CE}, 0);
        tick();
        chk("seq_valid", {31'd0, bus.instr_valid}, 1);
        chk("seq_hold_ce", {31'd0, bus.CE}, 1);
        wait_hs(b + 3);
        bus.halt = 1'b1;
        wait_hs(b + 4);
        bus.halt = 1'b0;
        n = hs_cyc.size();
        for (int k = n - 3; k < n; k++) chk("seq_period", hs_cyc[k] - hs_cyc[k-1], 3);
        chk("seq_end_pc", {28'd0, bus.pc}, 4);
        chk("seq_end_busy", {31'd0, bus.busy}, 0);

        // jump in IDLE to E, wrap through F -> 0 -> 1
        bus.jmp = 1'b1;
        bus.jmp_addr = 4'hE;
        tick();
        bus.jmp = 1'b0;
        chk("wrap_pc_load", {28'd0, bus.ABUS}, 32'hE);
        chk("wrap_idle_ce", {31'd0, bus.CE}, 1);
        b = hs_cnt;
        push(4'hE); push(4'hF); push(4'h0); push(4'h1);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_hs(b + 3);
        bus.halt = 1'b1;
        wait_hs(b + 4);
        bus.halt = 1'b0;
        chk("wrap_end_pc", {28'd0, bus.pc}, 2);

        // backpressure at pc=2
        b = hs_cnt;
        bus.instr_ready = 1'b0;
        push(4'h2); push(4'h3);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        n = 0;
        while (!bus.instr_valid && n < 10) begin
            tick();
            n++;
        end
        chk("bp_valid_seen", {31'd0, bus.instr_valid}, 1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_ce", {31'd0, bus.CE}, 1);
            chk("bp_hold", {16'd0, bus.opcode, bus.operand, bus.pc, bus.ABUS}, 32'h1222);
            chk("bp_valid", {31'd0, bus.instr_valid}, 1);
            tick();
        end
        bus.instr_ready = 1'b1;
        tick();
        chk("bp_next_ce", {31'd0, bus.CE}, 0);
        chk("bp_next_abus", {28'd0, bus.ABUS}, 3);
        chk("bp_valid_fall", {31'd0, bus.instr_valid}, 0);
        bus.halt = 1'b1;
        wait_hs(b + 2);
        bus.halt = 1'b0;
        chk("bp_end_pc", {28'd0, bus.pc}, 4);

        // start+jmp together to 3, then jump to 9 at the handshake
        b = hs_cnt;
        push(4'h3); push(4'h9);
        bus.jmp = 1'b1;
        bus.jmp_addr = 4'h3;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.jmp_addr = 4'h9;
        chk("jmp_start_abus", {28'd0, bus.ABUS}, 3);
        chk("jmp_start_ce", {31'd0, bus.CE}, 0);
        wait_hs(b + 1);
        chk("jmp_hs_ce", {31'd0, bus.CE}, 0);
        chk("jmp_hs_abus", {28'd0, bus.ABUS}, 9);
        bus.jmp = 1'b0;
        bus.halt = 1'b1;
        wait_hs(b + 2);
        bus.halt = 1'b0;
        chk("jmp_end_pc", {28'd0, bus.pc}, 32'hA);

        // halt raised during ACCESS at pc=2
        b = hs_cnt;
        push(4'h2);
        bus.jmp = 1'b1;
        bus.jmp_addr = 4'h2;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.jmp = 1'b0;
        bus.halt = 1'b1;
        wait_hs(b + 1);
        chk("halt_pc", {28'd0, bus.pc}, 3);
        chk("halt_ce", {31'd0, bus.CE}, 1);
        chk("halt_busy", {31'd0, bus.busy}, 0);
        bus.start = 1'b1;
        repeat (3) tick();
        chk("halt_blocks_start", {31'd0, bus.busy}, 0);
        bus.start = 1'b0;
        bus.halt = 1'b0;

        // reset during ACCESS
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("racc_ce_before", {31'd0, bus.CE}, 0);
        rst_n = 1'b0;
        tick();
        chk("racc_ce", {31'd0, bus.CE}, 1);
        chk("racc_pc", {28'd0, bus.pc}, 0);
        chk("racc_valid_busy", {30'd0, bus.instr_valid, bus.busy}, 0);
        rst_n = 1'b1;

        // reset during HOLD
        bus.instr_ready = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        chk("rhold_valid_before", {31'd0, bus.instr_valid}, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rhold_valid", {31'd0, bus.instr_valid}, 0);
        chk("rhold_regs", {20'd0, bus.opcode, bus.operand, bus.pc}, 0);
        chk("rhold_ce", {31'd0, bus.CE}, 1);
        bus.instr_ready = 1'b1;
        repeat (3) tick();
        chk("rhold_idle", {31'd0, bus.busy}, 0);

        chk("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
